fpga_ddr3_example_if0_dmaster_b2p: RTL and testbench

Receive-side byte-stream decoder for the debug master path. It converts a raw 8-bit byte stream from the host link into an Avalon-ST packet stream with start/end-of-packet and channel. It does this by interpreting in-band framing characters: SOP 0x7A, EOP 0x7B, CHANNEL 0x7C and ESCAPE 0x7D. It is the inverse of the transmit-side packets-to-bytes encoder and sits between the byte source and the channel adapter feeding the master.

---
 rtl/fpga_ddr3_example_if0_dmaster_b2p_pkg.sv | 17 +
 rtl/fpga_ddr3_example_if0_dmaster_b2p.sv | 143 ++++++++++++++
 tb/tb_fpga_ddr3_example_if0_dmaster_b2p.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/fpga_ddr3_example_if0_dmaster_b2p_pkg.sv
// rtl/fpga_ddr3_example_if0_dmaster_b2p_pkg.sv - framing constants and decode states shared by the byte/packet converters
package fpga_ddr3_example_if0_dmaster_b2p_pkg;

    localparam logic [7:0] SOP_CHAR  = 8'h7A;
    localparam logic [7:0] EOP_CHAR  = 8'h7B;
    localparam logic [7:0] CHAN_CHAR = 8'h7C;
    localparam logic [7:0] ESC_CHAR  = 8'h7D;
    localparam logic [7:0] ESC_XOR   = 8'h20;

    typedef enum logic [1:0] {
        S_DATA     = 2'd0,
        S_ESC      = 2'd1,
        S_CHAN     = 2'd2,
        S_CHAN_ESC = 2'd3
    } b2p_state_e;

endpackage

// File: rtl/fpga_ddr3_example_if0_dmaster_b2p.sv
// rtl/fpga_ddr3_example_if0_dmaster_b2p.sv - byte stream to packet stream decoder for the debug master receive path
module fpga_ddr3_example_if0_dmaster_b2p
    import fpga_ddr3_example_if0_dmaster_b2p_pkg::*;
#(
    parameter int CHANNEL_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     in_ready,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [7:0]               out_data,
    output logic                     out_startofpacket,
    output logic                     out_endofpacket,
    output logic [CHANNEL_WIDTH-1:0] out_channel
);

    b2p_state_e               state_q;
    b2p_state_e               state_next;
    logic                     sop_pend_q;
    logic                     eop_pend_q;
    logic [CHANNEL_WIDTH-1:0] channel_q;

    logic                     accept;
    logic                     emit;
    logic [7:0]               emit_data;
    logic                     set_sop;
    logic                     set_eop;
    logic                     load_chan;
    logic [7:0]               chan_byte;
    logic [CHANNEL_WIDTH-1:0] chan_val;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    generate
        if (CHANNEL_WIDTH > 8) begin : g_chan_wide
            assign chan_val = {{(CHANNEL_WIDTH-8){1'b0}}, chan_byte};
        end else if (CHANNEL_WIDTH == 8) begin : g_chan_exact
            assign chan_val = chan_byte;
        end else begin : g_chan_narrow
            assign chan_val = chan_byte[CHANNEL_WIDTH-1:0];
        end
    endgenerate

    // Decode state only advances on accepted bytes, so a stalled output freezes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_DATA;
        end else if (accept) begin
            state_q <= state_next;
        end
    end

    always_comb begin
        state_next = state_q;
        case (state_q)
            S_DATA: begin
                if (in_data == CHAN_CHAR) begin
                    state_next = S_CHAN;
                end else if (in_data == ESC_CHAR) begin
                    state_next = S_ESC;
                end
            end
            S_ESC:      state_next = S_DATA;
            S_CHAN:     state_next = (in_data == ESC_CHAR) ? S_CHAN_ESC : S_DATA;
            S_CHAN_ESC: state_next = S_DATA;
            default:    state_next = S_DATA;
        endcase
    end

    always_comb begin
        emit      = 1'b0;
        emit_data = in_data;
        set_sop   = 1'b0;
        set_eop   = 1'b0;
        load_chan = 1'b0;
        chan_byte = in_data;
        case (state_q)
            S_DATA: begin
                case (in_data)
                    SOP_CHAR:  set_sop = 1'b1;
                    EOP_CHAR:  set_eop = 1'b1;
                    CHAN_CHAR: ;
                    ESC_CHAR:  ;
                    default:   emit = 1'b1;
                endcase
            end
            // Escaped bytes are always payload, even if they decode to a framing code.
            S_ESC: begin
                emit      = 1'b1;
                emit_data = in_data ^ ESC_XOR;
            end
            S_CHAN: begin
                load_chan = (in_data != ESC_CHAR);
            end
            S_CHAN_ESC: begin
                load_chan = 1'b1;
                chan_byte = in_data ^ ESC_XOR;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sop_pend_q <= 1'b0;
            eop_pend_q <= 1'b0;
            channel_q  <= '0;
        end else if (accept) begin
            if (emit) begin
                sop_pend_q <= 1'b0;
                eop_pend_q <= 1'b0;
            end else begin
                if (set_sop) sop_pend_q <= 1'b1;
                if (set_eop) eop_pend_q <= 1'b1;
            end
            if (load_chan) channel_q <= chan_val;
        end
    end

    // Single output register: reloads whenever it is empty or being drained.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid         <= 1'b0;
            out_data          <= 8'h00;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= 1'b0;
            out_channel       <= '0;
        end else if (in_ready) begin
            out_valid <= accept && emit;
            if (accept && emit) begin
                out_data          <= emit_data;
                out_startofpacket <= sop_pend_q;
                out_endofpacket   <= eop_pend_q;
                out_channel       <= channel_q;
            end
        end
    end

endmodule

// File: tb/tb_fpga_ddr3_example_if0_dmaster_b2p.sv
// tb/tb_fpga_ddr3_example_if0_dmaster_b2p.sv - vector-table bench for the byte to packet decoder
module tb_fpga_ddr3_example_if0_dmaster_b2p;

    logic       clk;
    logic       reset;
    logic       in_ready;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_startofpacket;
    logic       out_endofpacket;
    logic [7:0] out_channel;

    fpga_ddr3_example_if0_dmaster_b2p #(.CHANNEL_WIDTH(8)) dut (
        .clk               (clk),
        .reset             (reset),
        .in_ready          (in_ready),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .out_ready         (out_ready),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket),
        .out_channel       (out_channel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       v;
        logic [7:0] d;
        logic       r;
        logic       eov;
        logic [7:0] ed;
        logic       es;
        logic       ee;
        logic [7:0] ech;
        logic       eir;
    } vec_t;

    vec_t tbl[80];
    int   n_vec;
    int   n_checks;
    int   n_pass;

    typedef struct {
        logic [7:0] d;
        logic       s;
        logic       e;
        logic [7:0] c;
    } beat_t;

    beat_t got[$];
    logic  mon_en;

    task automatic add(input logic rst, input logic v, input logic [7:0] d, input logic r,
                       input logic eov, input logic [7:0] ed, input logic es, input logic ee,
                       input logic [7:0] ech, input logic eir);
        tbl[n_vec] = '{rst, v, d, r, eov, ed, es, ee, ech, eir};
        n_vec++;
    endtask

    // Shorthands: x = byte in with out_ready=1 and nothing expected; o = byte in, expect an output.
    task automatic x(input logic v, input logic [7:0] d);
        add(1'b0, v, d, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic o(input logic v, input logic [7:0] d, input logic [7:0] ed,
                     input logic es, input logic ee, input logic [7:0] ech);
        add(1'b0, v, d, 1'b1, 1'b1, ed, es, ee, ech, 1'b1);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && out_valid && out_ready) begin
            got.push_back('{out_data, out_startofpacket, out_endofpacket, out_channel});
        end
    end

    initial begin
        logic [7:0] burst[10];
        int         n_data;
        int         budget;
        logic       took;

        n_vec    = 0;
        n_checks = 0;
        n_pass   = 0;
        mon_en   = 1'b0;

        // reset state
        add(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        // basic packet 7C 03 7A 11 22 7B 33
        x(1, 8'h7C); x(1, 8'h03); x(1, 8'h7A); x(1, 8'h11);
        o(1, 8'h22, 8'h11, 1, 0, 8'h03);
        o(1, 8'h7B, 8'h22, 0, 0, 8'h03);
        x(1, 8'h33);
        o(0, 8'h00, 8'h33, 0, 1, 8'h03);
        x(0, 8'h00);
        // escapes 7A 7D 5A 7D 5D 7B 7D 5B
        x(1, 8'h7A); x(1, 8'h7D); x(1, 8'h5A);
        o(1, 8'h7D, 8'h7A, 1, 0, 8'h03);
        x(1, 8'h5D);
        o(1, 8'h7B, 8'h7D, 0, 0, 8'h03);
        x(1, 8'h7D); x(1, 8'h5B);
        o(0, 8'h00, 8'h7B, 0, 1, 8'h03);
        x(0, 8'h00);
        // escaped channel, mid-packet channel switch
        x(1, 8'h7C); x(1, 8'h7D); x(1, 8'h5C); x(1, 8'h7A); x(1, 8'h01);
        o(1, 8'h7C, 8'h01, 1, 0, 8'h7C);
        x(1, 8'h05); x(1, 8'h02);
        o(1, 8'h7B, 8'h02, 0, 0, 8'h05);
        x(1, 8'h03);
        o(0, 8'h00, 8'h03, 0, 1, 8'h05);
        x(0, 8'h00);
        // single-byte packet
        x(1, 8'h7A); x(1, 8'h7B); x(1, 8'h44);
        o(0, 8'h00, 8'h44, 1, 1, 8'h05);
        x(0, 8'h00);
        // reset with sop pending and in S_ESC
        x(1, 8'h7A); x(1, 8'h7D);
        add(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        x(1, 8'h5A);
        o(0, 8'h00, 8'h5A, 0, 0, 8'h00);
        // back-to-back into a 4-cycle stall, then release
        x(1, 8'hA1);
        for (int i = 0; i < 4; i++) begin
            add(1'b0, 1'b1, 8'hA2, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b0, 8'h00, 1'b0);
        end
        o(1, 8'hA2, 8'hA1, 0, 0, 8'h00);
        o(1, 8'hA3, 8'hA2, 0, 0, 8'h00);
        o(0, 8'h00, 8'hA3, 0, 0, 8'h00);
        x(0, 8'h00);

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < n_vec; i++) begin
            @(posedge clk);
            #1;
            reset     = tbl[i].rst;
            in_valid  = tbl[i].v;
            in_data   = tbl[i].d;
            out_ready = tbl[i].r;
            #1;
            chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].eov));
            chk($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(tbl[i].eir));
            if (tbl[i].eov) begin
                chk($sformatf("row%0d out_data", i), 32'(out_data), 32'(tbl[i].ed));
                chk($sformatf("row%0d sop", i), 32'(out_startofpacket), 32'(tbl[i].es));
                chk($sformatf("row%0d eop", i), 32'(out_endofpacket), 32'(tbl[i].ee));
                chk($sformatf("row%0d channel", i), 32'(out_channel), 32'(tbl[i].ech));
            end
        end

        // Random backpressure burst: SOP, 01..07, EOP, 08 on channel 0
        burst = '{8'h7A, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h7B, 8'h08};
        n_data = 8;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        mon_en   = 1'b1;
        for (int b = 0; b < 10; b++) begin
            in_valid = 1'b1;
            in_data  = burst[b];
            took     = 1'b0;
            budget   = 0;
            while (!took && budget < 50) begin
                out_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                took = in_ready;
                @(posedge clk);
                #1;
                budget++;
            end
            if (!took) chk($sformatf("burst byte%0d accept timeout", b), 32'(took), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b0;
        chk("burst count", 32'(got.size()), 32'(n_data));
        for (int k = 0; k < got.size() && k < n_data; k++) begin
            chk($sformatf("burst%0d data", k), 32'(got[k].d), 32'(k + 1));
            chk($sformatf("burst%0d sop", k), 32'(got[k].s), 32'(k == 0));
            chk($sformatf("burst%0d eop", k), 32'(got[k].e), 32'(k == n_data - 1));
            chk($sformatf("burst%0d channel", k), 32'(got[k].c), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
